mmio_fifo_responder: RTL and testbench

MMIO_FIFO_RESPONDER -- requirements
Module: mmio_fifo_responder

---
 rtl/mmio_fifo_responder.sv | 148 ++++++++++++++
 tb/tb_mmio_fifo_responder.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_fifo_responder.sv
// Memory-mapped 32-bit FIFO, status/control words and a 16-bit display latch in the 0x7C-0x7F window.
// Define MMIO_FIFO_IRQ_EN to build the registered watermark/overflow interrupt; otherwise irq is tied low.
module mmio_fifo_responder #(
  parameter int DEPTH = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CS,
  input  logic        WE,
  input  logic [6:0]  ADDR,
  inout  wire  [31:0] Mem_Bus,
  output logic [15:0] disp_value,
  output logic        irq
);

  localparam int            PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]    DEPTH_C  = 4'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_STATUS = 2'd1,
    REG_CTRL   = 2'd2,
    REG_DISP   = 2'd3
  } reg_e;

  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [3:0]    count;
  logic          overflow;
  logic          underflow;
  logic [31:0]   rd_hold;
  logic          prev_sel;
  logic          prev_we;
  logic [1:0]    prev_addr;

  logic          sel;
  logic          start;
  logic          full;
  logic          empty;
  logic          push;
  reg_e          reg_sel;
  logic [31:0]   rd_data;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign sel     = CS && (ADDR[6:2] == 5'b11111);
  assign reg_sel = reg_e'(ADDR[1:0]);
  // A held CS with unchanged ADDR/WE is the same access, so only its first cycle commits.
  assign start   = sel && !(prev_sel && (prev_addr == ADDR[1:0]) && (prev_we == WE));
  assign full    = (count == DEPTH_C);
  assign empty   = (count == 4'd0);
  assign push    = start && WE && (reg_sel == REG_DATA) && !full && !RST;

  // DATA keeps returning the popped word for the rest of a held read.
  always_comb begin
    rd_data = '0;
    case (reg_sel)
      REG_DATA:   rd_data = start ? (empty ? 32'h0 : mem[head]) : rd_hold;
      REG_STATUS: rd_data = {24'h0, underflow, overflow, full, empty, count};
      REG_CTRL:   rd_data = '0;
      REG_DISP:   rd_data = {16'h0, disp_value};
      default:    rd_data = '0;
    endcase
  end

  assign Mem_Bus = (sel && !WE) ? rd_data : 32'bz;

  always_ff @(posedge CLK) begin
    if (push) mem[tail] <= Mem_Bus;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      count      <= 4'd0;
      head       <= '0;
      tail       <= '0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
      disp_value <= 16'h0000;
      rd_hold    <= 32'h0;
      prev_sel   <= 1'b0;
      prev_we    <= 1'b0;
      prev_addr  <= 2'd0;
    end else begin
      prev_sel  <= sel;
      prev_we   <= WE;
      prev_addr <= ADDR[1:0];
      if (start) begin
        case (reg_sel)
          REG_DATA: begin
            if (WE) begin
              if (full) overflow <= 1'b1;
              else begin
                tail  <= ptr_inc(tail);
                count <= count + 4'd1;
              end
            end else begin
              rd_hold <= rd_data;
              if (empty) underflow <= 1'b1;
              else begin
                head  <= ptr_inc(head);
                count <= count - 4'd1;
              end
            end
          end
          REG_STATUS: begin
            if (WE) begin
              overflow  <= 1'b0;
              underflow <= 1'b0;
            end
          end
          REG_CTRL: begin
            if (WE) begin
              if (Mem_Bus[0]) begin
                count <= 4'd0;
                head  <= '0;
                tail  <= '0;
              end
              if (Mem_Bus[1]) begin
                overflow  <= 1'b0;
                underflow <= 1'b0;
              end
            end
          end
          REG_DISP: begin
            if (WE) disp_value <= Mem_Bus[15:0];
          end
          default: ;
        endcase
      end
    end
  end

`ifdef MMIO_FIFO_IRQ_EN
  // Sampled from registered state, so irq trails the commit that caused it by one cycle.
  always_ff @(posedge CLK) begin
    if (RST) irq <= 1'b0;
    else     irq <= (count >= 4'(DEPTH / 2)) || overflow;
  end
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_mmio_fifo_responder.sv
// Bench for mmio_fifo_responder: directed vector table, hand-written reset/irq sequences,
// then random traffic against a queue-based model of the register window.
module tb_mmio_fifo_responder;

  localparam int DEPTH = 8;
`ifdef MMIO_FIFO_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST;
  logic        CS;
  logic        WE;
  logic [6:0]  ADDR;
  wire  [31:0] Mem_Bus;
  logic [15:0] disp_value;
  logic        irq;
  logic [31:0] drv_data;
  logic        drv_en;

  int checks = 0;
  int errors = 0;

  assign Mem_Bus = drv_en ? drv_data : 32'bz;

  always #5 CLK = ~CLK;

  mmio_fifo_responder #(.DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .CS(CS), .WE(WE), .ADDR(ADDR),
    .Mem_Bus(Mem_Bus), .disp_value(disp_value), .irq(irq)
  );

  typedef struct {
    logic        we;
    logic [6:0]  addr;
    logic [31:0] data;
    int          hold;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  // Model state for the random phase
  logic [31:0] mq[$];
  logic        m_ovf, m_udf, m_irq, m_psel, m_pwe;
  logic [1:0]  m_paddr;
  logic [15:0] m_disp;
  logic [31:0] m_hold;

  function automatic void addVec(input logic we, input logic [6:0] addr, input logic [31:0] data,
                                 input int hold, input logic chk, input logic [31:0] exp);
    vec_t v;
    v.we = we; v.addr = addr; v.data = data; v.hold = hold; v.chk = chk; v.exp = exp;
    vecs.push_back(v);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drives one cycle just after the posedge and returns at the mid-cycle sample point.
  task automatic applyStimulus(input logic rst, input logic cs, input logic we,
                               input logic [6:0] addr, input logic [31:0] data);
    @(posedge CLK);
    #1;
    RST = rst; CS = cs; WE = we; ADDR = addr; drv_data = data; drv_en = we;
    #3;
  endtask

  task automatic doAccess(input logic we, input logic [6:0] addr, input logic [31:0] data,
                          input int hold, input logic chk, input logic [31:0] exp, input string name);
    for (int h = 0; h < hold; h++) begin
      applyStimulus(1'b0, 1'b1, we, addr, data);
      if (chk) checkOutput($sformatf("%s_c%0d", name, h), Mem_Bus, exp);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 7'h00, 32'h0);
  endtask

  function automatic logic [31:0] modelStatus();
    int n = mq.size();
    return {24'h0, m_udf, m_ovf, (n == DEPTH), (n == 0), 4'(n)};
  endfunction

  task automatic randomPhase(input int cycles);
    logic        rst, cs, we, sel, st, nirq;
    logic [6:0]  addr;
    logic [31:0] data, exp;
    int          r;
    cs = 0; we = 0; addr = 0; data = 0;
    for (int c = 0; c < cycles; c++) begin
      rst = ($urandom_range(99) == 0);
      if ($urandom_range(9) >= 3) begin
        cs = ($urandom_range(9) != 0);
        we = 1'($urandom_range(1));
        r  = $urandom_range(99);
        if      (r < 55) addr = 7'h7C;
        else if (r < 70) addr = 7'h7D;
        else if (r < 74) addr = 7'h7E;
        else if (r < 85) addr = 7'h7F;
        else             addr = 7'($urandom_range(123));
        data = $urandom();
      end
      applyStimulus(rst, cs, we, addr, data);
      sel = cs && (addr[6:2] == 5'h1F);
      st  = sel && !(m_psel && (m_paddr == addr[1:0]) && (m_pwe == we));
      if (sel && !we) begin
        case (addr[1:0])
          2'd0:    exp = st ? ((mq.size() > 0) ? mq[0] : 32'h0) : m_hold;
          2'd1:    exp = modelStatus();
          2'd2:    exp = 32'h0;
          default: exp = {16'h0, m_disp};
        endcase
        checkOutput($sformatf("rand%0d_rd", c), Mem_Bus, exp);
      end
      checkOutput($sformatf("rand%0d_disp", c), {16'h0, disp_value}, {16'h0, m_disp});
      checkOutput($sformatf("rand%0d_irq", c), {31'h0, irq}, {31'h0, m_irq});
      if (rst) begin
        mq.delete();
        m_ovf = 0; m_udf = 0; m_irq = 0; m_disp = 0; m_psel = 0; m_pwe = 0; m_paddr = 0;
      end else begin
        nirq = IRQ_ON && ((mq.size() >= DEPTH / 2) || m_ovf);
        if (st) begin
          case (addr[1:0])
            2'd0: begin
              if (we) begin
                if (mq.size() == DEPTH) m_ovf = 1;
                else mq.push_back(data);
              end else begin
                m_hold = (mq.size() > 0) ? mq[0] : 32'h0;
                if (mq.size() > 0) void'(mq.pop_front());
                else m_udf = 1;
              end
            end
            2'd1: if (we) begin m_ovf = 0; m_udf = 0; end
            2'd2: if (we) begin
              if (data[0]) mq.delete();
              if (data[1]) begin m_ovf = 0; m_udf = 0; end
            end
            default: if (we) m_disp = data[15:0];
          endcase
        end
        m_psel = sel; m_pwe = we; m_paddr = addr[1:0];
        m_irq = nirq;
      end
    end
  endtask

  initial begin
    RST = 1; CS = 0; WE = 0; ADDR = 0; drv_data = 0; drv_en = 0;

    addVec(0, 7'h7D, 0, 1, 1, 32'h10);
    addVec(0, 7'h7F, 0, 1, 1, 32'h0);
    addVec(1, 7'h7C, 32'h11111111, 1, 0, 0);
    addVec(1, 7'h7C, 32'h22222222, 1, 0, 0);
    addVec(1, 7'h7C, 32'h33333333, 1, 0, 0);
    addVec(0, 7'h7D, 0, 1, 1, 32'h03);
    addVec(0, 7'h7C, 0, 1, 1, 32'h11111111);
    addVec(0, 7'h7C, 0, 1, 1, 32'h22222222);
    addVec(0, 7'h7C, 0, 1, 1, 32'h33333333);
    addVec(0, 7'h7D, 0, 1, 1, 32'h10);
    for (int i = 0; i < 9; i++) addVec(1, 7'h7C, 32'hA0 + i, 1, 0, 0);
    addVec(0, 7'h7D, 0, 1, 1, 32'h68);
    addVec(1, 7'h7D, 0, 1, 0, 0);
    addVec(0, 7'h7D, 0, 1, 1, 32'h28);
    for (int i = 0; i < 8; i++) addVec(0, 7'h7C, 0, 1, 1, 32'hA0 + i);
    addVec(0, 7'h7C, 0, 1, 1, 32'h0);
    addVec(0, 7'h7D, 0, 1, 1, 32'h90);
    addVec(1, 7'h7E, 32'h2, 1, 0, 0);
    addVec(0, 7'h7D, 0, 1, 1, 32'h10);
    addVec(1, 7'h7F, 32'hABCD1234, 1, 0, 0);
    addVec(0, 7'h7F, 0, 1, 1, 32'h1234);
    addVec(0, 7'h7E, 0, 1, 1, 32'h0);
    addVec(1, 7'h7C, 32'hC1, 2, 0, 0);
    addVec(1, 7'h7C, 32'hC2, 1, 0, 0);
    addVec(0, 7'h7D, 0, 1, 1, 32'h02);
    addVec(0, 7'h7C, 0, 2, 1, 32'hC1);
    addVec(0, 7'h7C, 0, 1, 1, 32'hC2);
    addVec(0, 7'h7D, 0, 1, 1, 32'h10);
    for (int i = 0; i < 5; i++) addVec(1, 7'h7C, 32'hB0 + i, 1, 0, 0);
    addVec(0, 7'h7D, 0, 1, 1, 32'h05);
    addVec(1, 7'h7E, 32'h1, 1, 0, 0);
    addVec(0, 7'h7D, 0, 1, 1, 32'h10);

    applyStimulus(1, 0, 0, 7'h00, 0);
    applyStimulus(0, 0, 0, 7'h00, 0);
    checkOutput("reset_disp", {16'h0, disp_value}, 32'h0);
    checkOutput("reset_irq", {31'h0, irq}, 32'h0);

    foreach (vecs[i]) doAccess(vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].hold,
                               vecs[i].chk, vecs[i].exp, $sformatf("vec%0d", i));

    // Outside the window nothing changes
    doAccess(1, 7'h3C, 32'h55, 1, 0, 0, "outside_wr");
    doAccess(0, 7'h7D, 0, 1, 1, 32'h10, "outside_status");

    // Reset while selected: reads see registered state, then everything clears
    doAccess(1, 7'h7C, 32'hD1, 1, 0, 0, "pre_rst_a");
    doAccess(1, 7'h7C, 32'hD2, 1, 0, 0, "pre_rst_b");
    applyStimulus(1, 1, 0, 7'h7D, 0);
    checkOutput("rst_rd_status", Mem_Bus, 32'h02);
    applyStimulus(0, 0, 0, 7'h00, 0);
    checkOutput("rst_disp", {16'h0, disp_value}, 32'h0);
    doAccess(0, 7'h7D, 0, 1, 1, 32'h10, "rst_status");
    doAccess(1, 7'h7F, 32'hABCD1234, 1, 0, 0, "disp_wr");
    checkOutput("disp_port", {16'h0, disp_value}, 32'h1234);
    doAccess(1, 7'h7C, 32'hE1, 1, 0, 0, "midpush_a");
    applyStimulus(1, 1, 1, 7'h7C, 32'hE2);
    applyStimulus(0, 0, 0, 7'h00, 0);
    checkOutput("midpush_disp", {16'h0, disp_value}, 32'h0);
    doAccess(0, 7'h7D, 0, 1, 1, 32'h10, "midpush_status");

    // Watermark interrupt timing around the 4th push and a flush
    for (int i = 0; i < 3; i++) doAccess(1, 7'h7C, 32'hF0 + i, 1, 0, 0, "irq_push");
    applyStimulus(0, 1, 1, 7'h7C, 32'hF3);
    applyStimulus(0, 0, 0, 7'h00, 0);
    checkOutput("irq_pre", {31'h0, irq}, 32'h0);
    applyStimulus(0, 0, 0, 7'h00, 0);
    checkOutput("irq_on", {31'h0, irq}, {31'h0, IRQ_ON});
    applyStimulus(0, 1, 1, 7'h7E, 32'h1);
    applyStimulus(0, 0, 0, 7'h00, 0);
    checkOutput("irq_hold", {31'h0, irq}, {31'h0, IRQ_ON});
    applyStimulus(0, 0, 0, 7'h00, 0);
    checkOutput("irq_off", {31'h0, irq}, 32'h0);

    applyStimulus(1, 0, 0, 7'h00, 0);
    mq.delete();
    m_ovf = 0; m_udf = 0; m_irq = 0; m_disp = 0; m_psel = 0; m_pwe = 0; m_paddr = 0; m_hold = 0;
    randomPhase(3000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
